// File: rtl/seg7_pkg.sv
// Shared 7-segment constants for the seg7 display blocks: digit patterns, blank/fill codes,
// capture FSM encoding and the BCD-to-segment lookup used by the display driver.
package seg7_pkg;

  // Index n holds the segment pattern for digit n (bit 6..0, active-high).
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'b0111111,  // 9
    7'b1111111,  // 8
    7'b0011100,  // 7
    7'b1110111,  // 6
    7'b0110111,  // 5
    7'b0011011,  // 4
    7'b0111101,  // 3
    7'b1101101,  // 2
    7'b0011000,  // 1
    7'b1111110   // 0
  };

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [3:0] BCD_FILL  = 4'hF;

  typedef enum logic {
    ST_SCAN = 1'b0,
    ST_HOLD = 1'b1
  } cap_state_e;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    return (bcd <= 4'd9) ? SEG_DIGITS[bcd] : SEG_BLANK;
  endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational 7-segment pattern to BCD decoder with blank/illegal flags.
// SEG7_CAPTURE_ERR_EN: illegal patterns raise err_o; otherwise they are reported as blank.
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] bcd_o,
  output logic       blank_o,
  output logic       err_o
);

  logic hit;

  always_comb begin
    bcd_o   = BCD_FILL;
    blank_o = 1'b0;
    err_o   = 1'b0;
    hit     = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (seg_i == SEG_DIGITS[i]) begin
        bcd_o = 4'(i);
        hit   = 1'b1;
      end
    end
    if (!hit) begin
`ifdef SEG7_CAPTURE_ERR_EN
      if (seg_i == SEG_BLANK) blank_o = 1'b1;
      else                    err_o   = 1'b1;
`else
      blank_o = 1'b1;
`endif
    end
  end

endmodule

// File: rtl/seg7_capture.sv
// Captures NUM_DIGITS stable digits from a multiplexed 7-seg bus into a BCD frame; frame valid
// STABLE_CYCLES+1 edges after the last digit's first sample, held until rd_ready. SEG7_CAPTURE_ERR_EN enables err_mask.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   dig_en,
  input  logic                    rd_ready,
  output logic                    out_valid,
  output logic [4*NUM_DIGITS-1:0] out_bcd,
  output logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [NUM_DIGITS-1:0]   err_mask
);

  localparam logic [3:0] STABLE_N = 4'(STABLE_CYCLES);

  cap_state_e              state_q;
  logic                    out_valid_q;
  logic [6:0]              seg_q, seg_prev_q;
  logic [NUM_DIGITS-1:0]   dig_q, dig_prev_q;
  logic [3:0]              cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0]   captured_q;
  logic [4*NUM_DIGITS-1:0] bcd_q;
  logic [NUM_DIGITS-1:0]   blank_q, err_q;

  logic                    onehot, same, reach;
  logic [NUM_DIGITS-1:0]   wr_mask;
  logic [3:0]              dec_bcd;
  logic                    dec_blank, dec_err;

  seg7_to_bcd u_dec (
    .seg_i   (seg_q),
    .bcd_o   (dec_bcd),
    .blank_o (dec_blank),
    .err_o   (dec_err)
  );

  assign onehot = (dig_q != '0) && ((dig_q & (dig_q - NUM_DIGITS'(1))) == '0);
  assign same   = ({seg_q, dig_q} == {seg_prev_q, dig_prev_q});

  always_comb begin
    cnt_d = '0;
    if (state_q == ST_SCAN) begin
      if (same && onehot)  cnt_d = (cnt_q == STABLE_N) ? cnt_q : cnt_q + 4'd1;
      else if (onehot)     cnt_d = 4'd1;
    end
  end

  // Only the edge where the run first reaches the threshold may write; saturation never rewrites.
  assign reach   = (state_q == ST_SCAN) && onehot && (cnt_d == STABLE_N) && (cnt_q != STABLE_N);
  assign wr_mask = reach ? (dig_q & ~captured_q) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q       <= '0;
      dig_q       <= '0;
      seg_prev_q  <= '0;
      dig_prev_q  <= '0;
      cnt_q       <= '0;
      captured_q  <= '0;
      bcd_q       <= '0;
      blank_q     <= '0;
      err_q       <= '0;
      state_q     <= ST_SCAN;
      out_valid_q <= 1'b0;
    end else begin
      seg_q      <= seg;
      dig_q      <= dig_en;
      seg_prev_q <= seg_q;
      dig_prev_q <= dig_q;
      cnt_q      <= cnt_d;
      case (state_q)
        ST_SCAN: begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (wr_mask[i]) begin
              bcd_q[4*i +: 4] <= dec_bcd;
              blank_q[i]      <= dec_blank;
              err_q[i]        <= dec_err;
              captured_q[i]   <= 1'b1;
            end
          end
          if (&captured_q) begin
            state_q     <= ST_HOLD;
            out_valid_q <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (rd_ready) begin
            state_q     <= ST_SCAN;
            out_valid_q <= 1'b0;
            captured_q  <= '0;
          end
        end
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign out_bcd    = bcd_q;
  assign blank_mask = blank_q;
  assign err_mask   = err_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Randomized scoreboard bench for seg7_capture: stimulus pushes expected frames from a cycle-level
// run-length model of the bus; a monitor pops and checks on each out_valid rise and during HOLD.
module tb_seg7_capture;

  localparam int ND = 4;
  localparam int SC = 4;

  localparam logic [6:0] PAT [10] = '{7'b1111110, 7'b0011000, 7'b1101101, 7'b0111101, 7'b0011011,
                                      7'b0110111, 7'b1110111, 7'b0011100, 7'b1111111, 7'b0111111};

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [6:0]      seg = '0;
  logic [ND-1:0]   dig_en = '0;
  logic            rd_ready = 1'b0;
  logic            out_valid;
  logic [4*ND-1:0] out_bcd;
  logic [ND-1:0]   blank_mask, err_mask;

  seg7_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg        (seg),
    .dig_en     (dig_en),
    .rd_ready   (rd_ready),
    .out_valid  (out_valid),
    .out_bcd    (out_bcd),
    .blank_mask (blank_mask),
    .err_mask   (err_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4*ND-1:0] bcd;
    logic [ND-1:0]   blank;
    logic [ND-1:0]   err;
    int              rise;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   vld_prev = 1'b0;
  logic rdy_e;

  // Model state for the frame being assembled.
  bit              frame_done;
  bit [ND-1:0]     cap;
  logic [4*ND-1:0] m_bcd;
  logic [ND-1:0]   m_blank, m_err;
  logic [6:0]      last_seg;
  logic [ND-1:0]   last_dig;
  int              run;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, want);
    end
  endtask

  // Returns {err, blank, bcd}.
  function automatic logic [5:0] decode(input logic [6:0] p);
    for (int i = 0; i < 10; i++) if (p == PAT[i]) return {2'b00, 4'(i)};
    if (p == 7'd0) return {2'b01, 4'hF};
`ifdef SEG7_CAPTURE_ERR_EN
    return {2'b10, 4'hF};
`else
    return {2'b01, 4'hF};
`endif
  endfunction

  task automatic new_frame();
    cap = '0; frame_done = 1'b0; run = 0;
    last_seg = '0; last_dig = '0;
    m_bcd = '0; m_blank = '0; m_err = '0;
  endtask

  // Drive one bus value for len cycles; a digit is captured on the SC-th cycle of a run of
  // identical one-hot values, the first time that digit is seen in the frame.
  task automatic drive(input logic [6:0] s, input logic [ND-1:0] d, input int len);
    logic [5:0] dc;
    exp_t e;
    for (int k = 0; k < len; k++) begin
      if (frame_done) return;
      @(negedge clk);
      seg = s; dig_en = d; rd_ready = 1'($urandom_range(0, 1));
      if (s == last_seg && d == last_dig) run++; else run = 1;
      last_seg = s; last_dig = d;
      if (d != 0 && (d & (d - 1)) == 0 && run == SC) begin
        for (int i = 0; i < ND; i++) begin
          if (d[i] && !cap[i]) begin
            dc = decode(s);
            cap[i] = 1'b1;
            m_bcd[4*i +: 4] = dc[3:0];
            m_blank[i] = dc[4];
            m_err[i] = dc[5];
          end
        end
        if (&cap) begin
          rd_ready = 1'b0;
          frame_done = 1'b1;
          e.bcd = m_bcd; e.blank = m_blank; e.err = m_err; e.rise = cyc + 3;
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic finish_frame(input int hold_len);
    int w;
    w = 0;
    while (!out_valid && w < 40) begin @(negedge clk); w++; end
    if (!out_valid) begin
      total++; bad++;
      $display("FAIL frame_timeout got=no out_valid want=out_valid within 40 cycles");
      exp_q.delete();
    end else begin
      for (int k = 0; k < hold_len; k++) begin
        @(negedge clk);
        seg = 7'($urandom); dig_en = ND'($urandom); rd_ready = 1'b0;
      end
      @(negedge clk); rd_ready = 1'b1; dig_en = '0;
    end
    @(negedge clk); rd_ready = 1'b0; dig_en = '0; seg = 7'($urandom);
    new_frame();
  endtask

  task automatic reset_pulse(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0; dig_en = '0; rd_ready = 1'b0;
    #1;
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_bcd"}, out_bcd, 0);
    check({tag, "_blank"}, blank_mask, 0);
    check({tag, "_err"}, err_mask, 0);
    @(negedge clk); rst_n = 1'b1;
    exp_q.delete();
    new_frame();
  endtask

  task automatic random_frame();
    int n, r, len;
    logic [6:0] s;
    logic [ND-1:0] d;
    n = 0;
    while (!frame_done && n < 60) begin
      r = $urandom_range(0, 9);
      d = (r == 0) ? ND'($urandom) : ND'(1 << $urandom_range(0, ND - 1));
      r = $urandom_range(0, 9);
      s = (r < 7) ? PAT[$urandom_range(0, 9)] : (r == 7) ? 7'd0 : 7'($urandom);
      len = $urandom_range(2, 6);
      drive(s, d, len);
      n++;
    end
    for (int i = 0; i < ND; i++) if (!cap[i]) drive(PAT[i], ND'(1 << i), SC);
  endtask

  // Monitor: checks each out_valid rise against the scoreboard and the held frame every HOLD cycle.
  always begin
    @(posedge clk);
    cyc++;
    rdy_e = rd_ready;
    #1;
    if (!rst_n) begin
      vld_prev = 1'b0;
    end else begin
      if (vld_prev && rdy_e) begin
        check("release_drop", out_valid, 0);
      end else if (vld_prev) begin
        check("hold_valid", out_valid, 1);
        check("hold_bcd", out_bcd, cur.bcd);
        check("hold_blank", blank_mask, cur.blank);
        check("hold_err", err_mask, cur.err);
      end else if (out_valid) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_frame got_bcd=%0h want=no frame", out_bcd);
        end else begin
          cur = exp_q.pop_front();
          check("rise_cycle", cyc, cur.rise);
          check("frame_bcd", out_bcd, cur.bcd);
          check("frame_blank", blank_mask, cur.blank);
          check("frame_err", err_mask, cur.err);
        end
      end
      vld_prev = out_valid;
    end
  end

  initial begin
    new_frame();
    repeat (3) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_bcd", out_bcd, 0);
    check("rst_blank", blank_mask, 0);
    check("rst_err", err_mask, 0);
    @(negedge clk); rst_n = 1'b1;

    // Digits "1","2","3","4", four cycles each.
    drive(PAT[1], 4'b0001, 4); drive(PAT[2], 4'b0010, 4);
    drive(PAT[3], 4'b0100, 4); drive(PAT[4], 4'b1000, 4);
    repeat (4) @(negedge clk);
    check("basic_valid", out_valid, 1);
    check("basic_bcd", out_bcd, 16'h4321);
    check("basic_masks", {blank_mask, err_mask}, 0);
    finish_frame(5);

    // Digit 0 held one cycle short of the threshold must not capture.
    drive(PAT[5], 4'b0001, 3); drive(PAT[1], 4'b0010, 4);
    drive(PAT[7], 4'b0100, 4); drive(PAT[8], 4'b1000, 4);
    drive(7'd0, 4'b0000, 4);
    check("short_run_valid", out_valid, 0);
    drive(PAT[6], 4'b0001, 4);
    finish_frame(3);

    // Illegal pattern on digit 2, then a 10-cycle hold with a busy bus.
    drive(PAT[0], 4'b0001, 4); drive(PAT[9], 4'b0010, 4);
    drive(7'b1010101, 4'b0100, 4); drive(PAT[8], 4'b1000, 4);
    repeat (4) @(negedge clk);
`ifdef SEG7_CAPTURE_ERR_EN
    check("illegal_err", err_mask, 4'b0100);
    check("illegal_blank", blank_mask, 4'b0000);
`else
    check("illegal_err", err_mask, 4'b0000);
    check("illegal_blank", blank_mask, 4'b0100);
`endif
    check("illegal_nibble", out_bcd[11:8], 4'hF);
    finish_frame(10);

    // Multi-hot and all-zero strobes must never write a slot.
    drive(PAT[2], 4'b0011, 8); drive(PAT[3], 4'b0000, 8);
    drive(PAT[6], 4'b0001, 4); drive(PAT[7], 4'b0010, 4);
    drive(PAT[9], 4'b0100, 4); drive(PAT[1], 4'b1000, 4);
    finish_frame(2);

    // Reset mid-frame discards the partial capture of digit 0.
    drive(PAT[7], 4'b0001, 6); drive(PAT[3], 4'b0010, 2);
    reset_pulse("midrst");
    drive(PAT[2], 4'b0010, 4); drive(PAT[3], 4'b0100, 4); drive(PAT[4], 4'b1000, 4);
    drive(7'd0, 4'b0000, 3);
    check("midrst_partial_valid", out_valid, 0);
    drive(PAT[5], 4'b0001, 4);
    finish_frame(4);

    // Reset while holding a frame.
    drive(PAT[8], 4'b0001, 4); drive(PAT[0], 4'b0010, 4);
    drive(PAT[6], 4'b0100, 4); drive(PAT[2], 4'b1000, 4);
    repeat (5) @(negedge clk);
    reset_pulse("holdrst");
    drive(7'd0, 4'b0000, 2);

    repeat (25) begin
      random_frame();
      finish_frame($urandom_range(1, 8));
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_capture.md
SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, meaning the number of multiplexed display digits captured per frame.
REQ-002 SHALL have parameter STABLE_CYCLES, default 4, meaning the consecutive identical samples required before a digit is accepted (legal range 2..15).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 seg  input  7  segment bus, bit 6..0, active-high.
REQ-006 dig_en  input  NUM_DIGITS  digit strobe, one-hot when a digit is driven.
REQ-007 rd_ready  input  1  consumer accepts the frame.
REQ-008 out_valid  output  1  captured frame available.
REQ-009 out_bcd  output  4*NUM_DIGITS  digit i at bits [4i+3:4i].
REQ-010 blank_mask  output  NUM_DIGITS  bit i set: digit i was blank (seg = 0000000).
REQ-011 err_mask  output  NUM_DIGITS  bit i set: digit i showed an illegal pattern.

Function
REQ-012 SHALL register seg and dig_en once (sample stage) before any comparison; combinational paths from inputs to outputs SHALL NOT exist.
REQ-013 SHALL decode with the team encoding: 0=1111110, 1=0011000, 2=1101101, 3=0111101, 4=0011011, 5=0110111, 6=1110111, 7=0011100, 8=1111111, 9=0111111.
REQ-014 Blank (0000000) SHALL decode to 4'hF with blank bit set; any other unlisted pattern SHALL decode to 4'hF with err bit set.
REQ-015 Stability counter SHALL increment when the sampled {seg,dig_en} equals the previous sample and dig_en is one-hot, else load 1 (one-hot) or 0 (not one-hot), saturating at STABLE_CYCLES.
REQ-016 A digit slot SHALL be written, and its captured bit set, on the edge at which the counter reaches STABLE_CYCLES; a slot already captured in the current frame SHALL NOT be rewritten.
REQ-017 dig_en all-zero or multi-hot SHALL never write a slot.
REQ-018 FSM states SCAN and HOLD; SCAN->HOLD on the edge after all NUM_DIGITS captured bits are set; out_valid=1 exactly while in HOLD.
REQ-019 In HOLD, out_bcd/blank_mask/err_mask SHALL stay constant and the bus SHALL be ignored; counter held at 0.
REQ-020 HOLD->SCAN on the edge where out_valid && rd_ready; all captured bits cleared on that same edge.
REQ-021 rd_ready while in SCAN SHALL have no effect.
REQ-022 Minimum latency from first stable sample of the last digit to out_valid: STABLE_CYCLES+1 edges after the sample stage.

Reset
REQ-023 While rst_n=0: out_valid=0, out_bcd=0, blank_mask=0, err_mask=0, FSM=SCAN, counters, sample stage and captured bits 0; takes effect immediately, including mid-frame or in HOLD.
REQ-024 First capture after rst_n release SHALL need a full STABLE_CYCLES run.

Configuration
REQ-025 Macro SEG7_CAPTURE_ERR_EN: when defined, illegal patterns set err_mask per REQ-014.
REQ-026 When SEG7_CAPTURE_ERR_EN is undefined, err_mask SHALL be constant 0 and illegal patterns SHALL be treated as blank (4'hF, blank bit set).

Structure
REQ-027 Shared package seg7_pkg SHALL hold the ten digit patterns, the blank pattern, the 4'hF fill code and the FSM state encoding; the existing BCD-to-segment driver SHALL use the same constants.
REQ-028 One sub-module, seg7_to_bcd (combinational 7-bit pattern -> 4-bit code plus blank/err flags), SHALL be instantiated once on the sample stage.

Verification
REQ-029 Drive digits 0..3 with "1","2","3","4", each held 4 cycles, dig_en one-hot -> out_valid=1, out_bcd=16'h4321, masks 0.
REQ-030 Hold digit 0 "5" for only 3 cycles then switch to digit 1 -> slot 0 not captured, out_valid stays 0.
REQ-031 Digit 2 pattern 1010101 held 4 cycles, others legal -> err_mask=4'b0100, out_bcd[11:8]=4'hF; with macro undefined blank_mask=4'b0100, err_mask=0.
REQ-032 Frame in HOLD, rd_ready=0 for 10 cycles while bus changes -> outputs unchanged; rd_ready=1 -> out_valid=0 next edge, new frame captured.
REQ-033 dig_en=4'b0011 for 8 cycles -> no slot written; rst_n low mid-frame -> all outputs 0 immediately, prior partial captures discarded.
